// File: rtl/seq_priority_encoder_if.sv
// Request/grant bundle for seq_priority_encoder: sticky request inputs and
// the valid/ready grant channel. slave = encoder side, master = requester/consumer side.
interface seq_priority_encoder_if #(
    parameter int N = 16
);
    localparam int W = $clog2(N);

    logic [N-1:0] req;
    logic         enable;
    logic         o_ready;
    logic         o_valid;
    logic [W-1:0] o_idx;
    logic [N-1:0] pend;
    logic         overflow;

    modport master (
        output req, enable, o_ready,
        input  o_valid, o_idx, pend, overflow
    );

    modport slave (
        input  req, enable, o_ready,
        output o_valid, o_idx, pend, overflow
    );
endinterface

// File: rtl/seq_priority_encoder.sv
// Registered N-to-log2(N) priority encoder with sticky request capture and a valid/ready grant.
// Define SEQ_PRIORITY_ENCODER_ROUND_ROBIN_EN for a rotating priority pointer; default is fixed priority.
module seq_priority_encoder #(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_priority_encoder_if.slave bus
);
    localparam int W = $clog2(N);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t       state;
    logic [N-1:0] pend_p0;
    logic         vld_p0;
    logic [W-1:0] idx_p0;
    logic         ovf_p0;
    logic [W-1:0] ptr;
    logic [W-1:0] sel;
    logic         grant;
    logic [N-1:0] clr;
    logic [N-1:0] set_v;

    // Scan ptr, ptr-1, ..., 0, N-1, ..., ptr+1; the first set bit wins.
    function automatic logic [W-1:0] pick_idx(input logic [N-1:0] p, input logic [W-1:0] start);
        logic [W-1:0] idx;
        logic         found;
        int           j;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) - k;
            if (j < 0) j = j + N;
            if (!found && p[j[W-1:0]]) begin
                idx   = j[W-1:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign sel   = pick_idx(pend_p0, ptr);
    assign grant = (pend_p0 != '0) && ((state == IDLE) || bus.o_ready);
    assign clr   = grant ? (N'(1) << sel) : '0;
    assign set_v = bus.req & {N{bus.enable}};

`ifdef SEQ_PRIORITY_ENCODER_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= W'(N - 1);
        end else if (grant) begin
            ptr <= (sel == '0) ? W'(N - 1) : sel - 1'b1;
        end
    end
`else
    assign ptr = W'(N - 1);
`endif

    // Capture and grant share one edge; a set landing on a just-cleared bit is a fresh request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pend_p0 <= '0;
            vld_p0  <= 1'b0;
            idx_p0  <= '0;
            ovf_p0  <= 1'b0;
        end else begin
            pend_p0 <= (pend_p0 & ~clr) | set_v;
            ovf_p0  <= |(set_v & pend_p0 & ~clr);
            case (state)
                IDLE: begin
                    if (grant) begin
                        idx_p0 <= sel;
                        vld_p0 <= 1'b1;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.o_ready) begin
                        if (grant) begin
                            idx_p0 <= sel;
                        end else begin
                            vld_p0 <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pend     = pend_p0;
    assign bus.o_valid  = vld_p0;
    assign bus.o_idx    = idx_p0;
    assign bus.overflow = ovf_p0;
endmodule

// File: tb/tb_seq_priority_encoder.sv
// Scoreboard bench for seq_priority_encoder: a set-based reference model queues expected grants,
// a negedge monitor pops them on each accepted transfer.
module tb_seq_priority_encoder;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_priority_encoder_if #(.N(N)) bus();
    seq_priority_encoder #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int acc_q[$];
    int sb_e;

    // Reference state: pending set, current output, priority start point.
    logic [N-1:0] mpend;
    logic         mvalid;
    int           midx;
    int           mptr;
    logic         movf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] p, input int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start - k + N) % N;
            if (p[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mpend  = '0;
        mvalid = 1'b0;
        midx   = 0;
        mptr   = N - 1;
        movf   = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic e, input logic rdy);
        logic [N-1:0] setv;
        logic [N-1:0] clrv;
        int g;
        setv = e ? r : '0;
        clrv = '0;
        if (mpend != '0 && (!mvalid || rdy)) begin
            g = pick(mpend, mptr);
            clrv = N'(1) << g;
            exp_q.push_back(g);
            mvalid = 1'b1;
            midx = g;
`ifdef SEQ_PRIORITY_ENCODER_ROUND_ROBIN_EN
            mptr = (g == 0) ? N - 1 : g - 1;
`endif
        end else if (mvalid && rdy) begin
            mvalid = 1'b0;
        end
        movf  = |(setv & mpend & ~clrv);
        mpend = (mpend & ~clrv) | setv;
    endtask

    task automatic compare_all();
        chk("pend", 32'(bus.pend), 32'(mpend));
        chk("overflow", 32'(bus.overflow), 32'(movf));
        chk("o_valid", 32'(bus.o_valid), 32'(mvalid));
        chk("o_idx", 32'(bus.o_idx), 32'(midx));
    endtask

    task automatic step(input logic [N-1:0] r, input logic e, input logic rdy);
        bus.req = r;
        bus.enable = e;
        bus.o_ready = rdy;
        model_edge(r, e, rdy);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int ncyc, input logic [N-1:0] r, input logic e);
        rst_n = 1'b0;
        bus.req = r;
        bus.enable = e;
        bus.o_ready = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            model_reset();
            @(posedge clk);
            #1;
            compare_all();
        end
        rst_n = 1'b1;
    endtask

    task automatic chk_seq(input string name, input int e0, input int e1, input int e2, input int e3);
        int ev[4];
        ev = '{e0, e1, e2, e3};
        chk({name, "_count"}, 32'(acc_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_q.size(); i++)
            chk(name, 32'(acc_q[i]), 32'(ev[i]));
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.o_valid === 1'b1 && bus.o_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_idx: got grant %0d expected none", bus.o_idx);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_idx", 32'(bus.o_idx), 32'(sb_e));
            end
            acc_q.push_back(int'(bus.o_idx));
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.req = '0;
        bus.enable = 1'b0;
        bus.o_ready = 1'b0;

        // Reset with all requests asserted
        do_reset(2, 16'hFFFF, 1'b1);

        // Single request
        step(16'h0020, 1'b1, 1'b1);
        chk("single_nogrant_yet", 32'(bus.o_valid), 32'd0);
        step(16'h0000, 1'b1, 1'b1);
        chk("single_valid", 32'(bus.o_valid), 32'd1);
        chk("single_idx", 32'(bus.o_idx), 32'd5);
        step(16'h0000, 1'b1, 1'b1);
        chk("single_drop", 32'(bus.o_valid), 32'd0);
        chk("single_pend", 32'(bus.pend), 32'd0);

        // Stall then drain
        do_reset(1, 16'h0000, 1'b1);
        acc_q.delete();
        step(16'h8421, 1'b1, 1'b0);
        repeat (3) step(16'h0000, 1'b1, 1'b0);
        chk("stall_idx", 32'(bus.o_idx), 32'd15);
        chk("stall_pend", 32'(bus.pend), 32'h0421);
        repeat (5) step(16'h0000, 1'b1, 1'b1);
        chk("drain_done", 32'(bus.o_valid), 32'd0);
        chk_seq("drain_order", 15, 10, 5, 0);

        // Priority mode with re-request on the granted bit
        do_reset(1, 16'h0000, 1'b1);
        acc_q.delete();
        step(16'h8003, 1'b1, 1'b1);
        step(16'h8000, 1'b1, 1'b1);
        chk("rerequest_no_ovf", 32'(bus.overflow), 32'd0);
        repeat (5) step(16'h0000, 1'b1, 1'b1);
`ifdef SEQ_PRIORITY_ENCODER_ROUND_ROBIN_EN
        chk_seq("prio_order", 15, 1, 0, 15);
`else
        chk_seq("prio_order", 15, 15, 1, 0);
`endif

        // Overflow and enable gating
        do_reset(1, 16'h0000, 1'b1);
        step(16'h8000, 1'b1, 1'b0);
        step(16'h0000, 1'b1, 1'b0);
        step(16'h0010, 1'b1, 1'b0);
        chk("ovf_first", 32'(bus.overflow), 32'd0);
        step(16'h0010, 1'b1, 1'b0);
        chk("ovf_second", 32'(bus.overflow), 32'd1);
        chk("ovf_pend", 32'(bus.pend), 32'h0010);
        step(16'hFFFF, 1'b0, 1'b0);
        chk("enable_off_pend", 32'(bus.pend), 32'h0010);
        chk("enable_off_ovf", 32'(bus.overflow), 32'd0);
        repeat (3) step(16'h0000, 1'b1, 1'b1);

        // Reset mid-stream
        do_reset(1, 16'h0000, 1'b1);
        step(16'h80F0, 1'b1, 1'b0);
        step(16'h0000, 1'b1, 1'b0);
        chk("mid_pend", 32'(bus.pend), 32'h00F0);
        chk("mid_valid", 32'(bus.o_valid), 32'd1);
        do_reset(1, 16'h0000, 1'b1);
        repeat (3) step(16'h0000, 1'b1, 1'b1);
        chk("mid_no_grant", 32'(bus.o_valid), 32'd0);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 800; c++) begin
            logic [N-1:0] r;
            logic e;
            logic rdy;
            r   = N'($urandom) & N'($urandom) & N'($urandom);
            e   = ($urandom_range(0, 7) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 99) == 0)
                do_reset(1, r, e);
            else
                step(r, e, rdy);
        end
        repeat (N + 2) step(16'h0000, 1'b1, 1'b1);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("final_idle", 32'(bus.o_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
